// File: rtl/threshold_sequencer.sv
// threshold_sequencer: streams a block of words from a source memory through
// an external pixel processor and writes the results to a destination memory.
// A DRAIN watchdog flags a processor that never signals completion.
module threshold_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            mode_cfg,
    input  logic [7:0]            proc_val_cfg,
    input  logic [15:0]           word_count,
    input  logic [15:0]           src_base,
    input  logic [15:0]           dst_base,
    output logic                  busy,
    output logic                  finished,
    output logic                  error,
    output logic                  rd_en,
    output logic [15:0]           rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  proc_vld,
    output logic                  proc_last,
    output logic [1:0]            proc_mode,
    output logic [7:0]            proc_val,
    output logic [DATA_WIDTH-1:0] proc_data_in,
    input  logic [DATA_WIDTH-1:0] proc_data_out,
    input  logic                  proc_data_out_vld,
    input  logic                  proc_done,
    output logic                  wr_en,
    output logic [15:0]           wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_FINISH} state_t;

    state_t                state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [7:0]            val_q, val_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           src_q, src_d;
    logic [15:0]           dst_q, dst_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic [TW-1:0]         drain_cnt_q, drain_cnt_d;
    logic                  done_seen_q, done_seen_d;
    logic                  error_q, error_d;
    logic                  finished_q, finished_d;
    logic                  rd_en_q, rd_en_d;
    logic                  rd_last_q, rd_last_d;
    logic [15:0]           rd_addr_q, rd_addr_d;
    logic                  proc_vld_q, proc_vld_d;
    logic                  proc_last_q, proc_last_d;
    logic                  wr_en_q, wr_en_d;
    logic [15:0]           wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    assign busy         = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign finished     = finished_q;
    assign error        = error_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign proc_vld     = proc_vld_q;
    assign proc_last    = proc_last_q;
    assign proc_mode    = busy ? mode_q : 2'd0;
    assign proc_val     = busy ? val_q : 8'd0;
    assign proc_data_in = rd_data;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;

    // Next-state logic: job sequencing, read issue, write capture and watchdog.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        val_d       = val_q;
        count_d     = count_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_seen_d = done_seen_q;
        error_d     = error_q;
        finished_d  = 1'b0;
        rd_en_d     = 1'b0;
        rd_last_d   = 1'b0;
        rd_addr_d   = rd_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        // Read data returns one cycle after rd_en, so the processor strobe is rd_en delayed.
        proc_vld_d  = rd_en_q;
        proc_last_d = rd_en_q & rd_last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d      = mode_cfg;
                    val_d       = proc_val_cfg;
                    count_d     = word_count;
                    src_d       = src_base;
                    dst_d       = dst_base;
                    error_d     = 1'b0;
                    wr_cnt_d    = 16'd0;
                    rd_cnt_d    = 16'd0;
                    drain_cnt_d = '0;
                    done_seen_d = 1'b0;
                    if (word_count == 16'd0) begin
                        state_d    = S_FINISH;
                        finished_d = 1'b1;
                    end else begin
                        // The first read goes out on the same edge that enters FEED.
                        state_d   = S_FEED;
                        rd_en_d   = 1'b1;
                        rd_addr_d = src_base;
                        rd_last_d = (word_count == 16'd1);
                        rd_cnt_d  = 16'd1;
                    end
                end
            end
            S_FEED: begin
                if (rd_cnt_q != count_q) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = src_q + rd_cnt_q;
                    rd_last_d = (rd_cnt_q == count_q - 16'd1);
                    rd_cnt_d  = rd_cnt_q + 16'd1;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (done_seen_q && (wr_cnt_q == count_q) && !wr_en_q) begin
                    state_d    = S_FINISH;
                    finished_d = 1'b1;
                end else if (drain_cnt_q == TW'(TIMEOUT - 1)) begin
                    error_d    = 1'b1;
                    state_d    = S_FINISH;
                    finished_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are accepted in FEED and DRAIN; beats beyond the job length are dropped.
        if (busy) begin
            if (proc_done) begin
                done_seen_d = 1'b1;
            end
            if (proc_data_out_vld && (wr_cnt_q != count_q)) begin
                wr_en_d   = 1'b1;
                wr_data_d = proc_data_out;
                wr_addr_d = dst_q + wr_cnt_q;
                wr_cnt_d  = wr_cnt_q + 16'd1;
            end
        end
    end

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'd0;
            val_q       <= 8'd0;
            count_q     <= 16'd0;
            src_q       <= 16'd0;
            dst_q       <= 16'd0;
            rd_cnt_q    <= 16'd0;
            wr_cnt_q    <= 16'd0;
            drain_cnt_q <= '0;
            done_seen_q <= 1'b0;
            error_q     <= 1'b0;
            finished_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_last_q   <= 1'b0;
            rd_addr_q   <= 16'd0;
            proc_vld_q  <= 1'b0;
            proc_last_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 16'd0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            val_q       <= val_d;
            count_q     <= count_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_seen_q <= done_seen_d;
            error_q     <= error_d;
            finished_q  <= finished_d;
            rd_en_q     <= rd_en_d;
            rd_last_q   <= rd_last_d;
            rd_addr_q   <= rd_addr_d;
            proc_vld_q  <= proc_vld_d;
            proc_last_q <= proc_last_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_threshold_sequencer.sv
// Testbench for threshold_sequencer: directed job table, random jobs scored
// against a job-level reference, and a reset-during-FEED sequence.
module tb_threshold_sequencer;

    localparam int DW = 32;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode_cfg;
    logic [7:0]    proc_val_cfg;
    logic [15:0]   word_count, src_base, dst_base;
    logic          busy, finished, error;
    logic          rd_en;
    logic [15:0]   rd_addr;
    logic [DW-1:0] rd_data;
    logic          proc_vld, proc_last;
    logic [1:0]    proc_mode;
    logic [7:0]    proc_val;
    logic [DW-1:0] proc_data_in, proc_data_out;
    logic          proc_data_out_vld, proc_done;
    logic          wr_en;
    logic [15:0]   wr_addr;
    logic [DW-1:0] wr_data;

    threshold_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_cfg(mode_cfg),
        .proc_val_cfg(proc_val_cfg), .word_count(word_count),
        .src_base(src_base), .dst_base(dst_base), .busy(busy),
        .finished(finished), .error(error), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .proc_vld(proc_vld), .proc_last(proc_last),
        .proc_mode(proc_mode), .proc_val(proc_val), .proc_data_in(proc_data_in),
        .proc_data_out(proc_data_out), .proc_data_out_vld(proc_data_out_vld),
        .proc_done(proc_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    endtask

    // Source memory contents as a pure function of address.
    function automatic logic [31:0] mem_f(input logic [15:0] a);
        return {~a, a + 16'h1234};
    endfunction

    // Stand-in processor transform.
    function automatic logic [31:0] model_proc(input logic [31:0] d, input logic [1:0] m, input logic [7:0] v);
        case (m)
            2'd1:    return d ^ {4{v}};
            2'd2:    return d + {24'd0, v};
            default: return d;
        endcase
    endfunction

    // Current job as the bench requested it.
    logic [1:0]  j_mode;
    logic [7:0]  j_val;
    logic [15:0] j_src;

    // ---------------- source memory: one-cycle read latency ----------------
    logic        mem_req;
    logic [15:0] mem_addr;
    initial begin
        rd_data = '0;
        forever begin
            @(negedge clk);
            mem_req  = rd_en;
            mem_addr = rd_addr;
            @(posedge clk);
            #1;
            if (mem_req) rd_data = mem_f(mem_addr);
        end
    end

    // ---------------- processor model with random result latency ----------------
    logic [31:0] pq[$];
    int          pt[$];
    int          p_cyc = 0;
    bit          p_active = 0, p_done_en = 0, p_done_sent = 1;
    int          p_wc = 0, p_out = 0, p_extra = 0;
    initial begin
        proc_data_out     = '0;
        proc_data_out_vld = 1'b0;
        proc_done         = 1'b0;
        forever begin
            @(negedge clk);
            p_cyc++;
            proc_data_out_vld = 1'b0;
            proc_done         = 1'b0;
            if (!rst_n) begin
                pq.delete();
                pt.delete();
            end else begin
                if (proc_vld) begin
                    pq.push_back(model_proc(proc_data_in, proc_mode, proc_val));
                    pt.push_back(p_cyc + int'($urandom_range(0, 3)));
                end
                if (pq.size() > 0 && pt[0] <= p_cyc) begin
                    proc_data_out     = pq.pop_front();
                    void'(pt.pop_front());
                    proc_data_out_vld = 1'b1;
                    p_out++;
                end else if (p_active && p_out >= p_wc && p_extra > 0) begin
                    proc_data_out     = $urandom;
                    proc_data_out_vld = 1'b1;
                    p_extra--;
                end else if (p_active && p_out >= p_wc && p_done_en && !p_done_sent) begin
                    proc_done   = 1'b1;
                    p_done_sent = 1;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    int          m_cyc, m_rd_first, m_rd_last_cyc, m_vld_cnt, m_align_err, m_din_err;
    int          m_last_cnt, m_last_idx, m_busy_cyc, m_cfg_err, m_hold_err, m_fin_cnt;
    int          m_err_at_fin;
    logic [15:0] rd_q[$];
    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic        prev_rst = 1'b0, prev_rd_en = 1'b0;
    logic [15:0] prev_rd_addr = '0, prev_wr_addr = '0;
    logic [31:0] prev_wr_data = '0;

    task automatic clear_mon();
        m_cyc = 0; m_rd_first = -1; m_rd_last_cyc = -1; m_vld_cnt = 0; m_align_err = 0;
        m_din_err = 0; m_last_cnt = 0; m_last_idx = -1; m_busy_cyc = 0; m_cfg_err = 0;
        m_hold_err = 0; m_fin_cnt = 0; m_err_at_fin = -1;
        rd_q.delete(); wa_q.delete(); wd_q.delete();
    endtask

    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            m_cyc++;
            if (rst_n && prev_rst) begin
                if (proc_vld !== prev_rd_en) m_align_err++;
                if (!rd_en && rd_addr !== prev_rd_addr) m_hold_err++;
                if (!wr_en && (wr_addr !== prev_wr_addr || wr_data !== prev_wr_data)) m_hold_err++;
            end
            if (rd_en) begin
                if (rd_q.size() == 0) m_rd_first = m_cyc;
                m_rd_last_cyc = m_cyc;
                rd_q.push_back(rd_addr);
            end
            if (proc_vld) begin
                if (proc_data_in !== mem_f(j_src + 16'(m_vld_cnt))) m_din_err++;
                if (proc_last) begin
                    m_last_cnt++;
                    m_last_idx = m_vld_cnt;
                end
                m_vld_cnt++;
            end else if (proc_last) begin
                m_last_cnt++;
            end
            if (busy) begin
                m_busy_cyc++;
                if (proc_mode !== j_mode || proc_val !== j_val) m_cfg_err++;
            end else if (!finished && (proc_mode !== 2'd0 || proc_val !== 8'd0)) begin
                m_cfg_err++;
            end
            if (wr_en) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
            end
            if (finished) begin
                m_fin_cnt++;
                m_err_at_fin = int'(error);
            end
            prev_rst     = rst_n;
            prev_rd_en   = rd_en;
            prev_rd_addr = rd_addr;
            prev_wr_addr = wr_addr;
            prev_wr_data = wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl_zero"}, int'({busy, finished, error, rd_en, proc_vld, proc_last, wr_en}), 0);
        check({tag, "_cfg_zero"}, int'({proc_mode, proc_val}), 0);
        check({tag, "_addr_zero"}, int'({rd_addr, wr_addr}), 0);
        check({tag, "_wr_data_zero"}, int'(wr_data), 0);
    endtask

    task automatic launch(input logic [15:0] wc, input logic [1:0] mode, input logic [7:0] val,
                          input logic [15:0] src, input logic [15:0] dst, input bit done_en, input int extra);
        j_mode = mode; j_val = val; j_src = src;
        clear_mon();
        pq.delete(); pt.delete();
        p_active = (wc != 16'd0); p_wc = int'(wc); p_out = 0; p_extra = extra;
        p_done_en = done_en; p_done_sent = 0;
        start = 1'b1; mode_cfg = mode; proc_val_cfg = val;
        word_count = wc; src_base = src; dst_base = dst;
        tick();
        // Config inputs change after acceptance; the job must not follow them.
        start = 1'b0; mode_cfg = 2'($urandom); proc_val_cfg = 8'($urandom);
        word_count = 16'($urandom_range(1, 40)); src_base = 16'($urandom); dst_base = 16'($urandom);
    endtask

    task automatic run_job(input logic [15:0] wc, input logic [1:0] mode, input logic [7:0] val,
                           input logic [15:0] src, input logic [15:0] dst, input bit done_en,
                           input int extra, input bit restart, input bit exp_err,
                           input logic [15:0] exp_last_rd);
        int bound, bad;
        bit got;
        tick();
        launch(wc, mode, val, src, dst, done_en, extra);
        check("error_clear_on_start", int'(error), 0);
        check("busy_after_start", int'(busy), int'(wc != 16'd0));
        if (restart) begin
            tick(); tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        bound = int'(wc) + TO + 40;
        got = 0;
        for (int c = 0; c < bound; c++) begin
            if (m_fin_cnt > 0) begin
                got = 1;
                break;
            end
            tick();
        end
        check("finished_within_bound", int'(got), 1);
        repeat (4) tick();

        check("rd_count", rd_q.size(), int'(wc));
        bad = 0;
        foreach (rd_q[i]) if (rd_q[i] !== 16'(src + 16'(i))) bad++;
        check("rd_addr_errors", bad, 0);
        if (wc != 16'd0) begin
            check("rd_last_addr", int'(rd_q[rd_q.size()-1]), int'(exp_last_rd));
            // rd_en is first seen at the monitor's second sample: the cycle after start is taken.
            check("rd_first_cycle", m_rd_first, 2);
            check("rd_contiguous", m_rd_last_cyc - m_rd_first + 1, int'(wc));
            check("proc_last_index", m_last_idx, int'(wc) - 1);
        end
        check("proc_vld_count", m_vld_cnt, int'(wc));
        check("proc_last_count", m_last_cnt, int'(wc != 16'd0));
        check("proc_vld_align_errors", m_align_err, 0);
        check("proc_data_in_errors", m_din_err, 0);
        check("write_count", wa_q.size(), int'(wc));
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++) begin
            if (wa_q[i] !== 16'(dst + 16'(i))) bad++;
            else if (wd_q[i] !== model_proc(mem_f(16'(src + 16'(i))), mode, val)) bad++;
        end
        check("write_errors", bad, 0);
        check("finished_pulses", m_fin_cnt, 1);
        check("error_at_finish", m_err_at_fin, int'(exp_err));
        check("error_sticky", int'(error), int'(exp_err));
        check("cfg_drive_errors", m_cfg_err, 0);
        check("hold_errors", m_hold_err, 0);
        if (wc != 16'd0 && !done_en) check("timeout_busy_cycles", m_busy_cyc, int'(wc) + TO);
        $display("job wc=%0d mode=%0d val=0x%02h src=0x%04h dst=0x%04h done=%0d extra=%0d restart=%0d reads=%0d writes=%0d error=%0d",
                 wc, mode, val, src, dst, done_en, extra, restart, rd_q.size(), wa_q.size(), error);
    endtask

    typedef struct {
        logic [15:0] wc;
        logic [1:0]  mode;
        logic [7:0]  val;
        logic [15:0] src;
        logic [15:0] dst;
        bit          done_en;
        int          extra;
        bit          restart;
        bit          exp_err;
        logic [15:0] exp_last_rd;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'd4, 2'd1, 8'h80, 16'h0010, 16'h0040, 1'b1, 0, 1'b0, 1'b0, 16'h0013};
        vecs[1] = '{16'd1, 2'd2, 8'h20, 16'h1000, 16'h2000, 1'b1, 0, 1'b0, 1'b0, 16'h1000};
        vecs[2] = '{16'd0, 2'd1, 8'h55, 16'h0300, 16'h0400, 1'b1, 0, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{16'd3, 2'd1, 8'h10, 16'h0500, 16'h0600, 1'b0, 0, 1'b0, 1'b1, 16'h0502};
        vecs[4] = '{16'd2, 2'd2, 8'h01, 16'h0700, 16'h0800, 1'b1, 0, 1'b0, 1'b0, 16'h0701};
        vecs[5] = '{16'd3, 2'd0, 8'h00, 16'hFFFE, 16'hFFFF, 1'b1, 0, 1'b0, 1'b0, 16'h0000};
        vecs[6] = '{16'd6, 2'd1, 8'h33, 16'h0A00, 16'h0B00, 1'b1, 2, 1'b1, 1'b0, 16'h0A05};

        rst_n = 1'b0; start = 1'b0; mode_cfg = '0; proc_val_cfg = '0;
        word_count = '0; src_base = '0; dst_base = '0;
        j_mode = '0; j_val = '0; j_src = '0;
        repeat (3) tick();
        check_outputs_zero("power_on_reset");
        rst_n = 1'b1;
        repeat (2) tick();

        foreach (vecs[i])
            run_job(vecs[i].wc, vecs[i].mode, vecs[i].val, vecs[i].src, vecs[i].dst,
                    vecs[i].done_en, vecs[i].extra, vecs[i].restart, vecs[i].exp_err, vecs[i].exp_last_rd);

        for (int n = 0; n < 16; n++) begin
            logic [15:0] wc, src, dst;
            logic [1:0]  mode;
            logic [7:0]  val;
            bit          done_en, restart;
            int          extra;
            wc      = 16'($urandom_range(0, 12));
            src     = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
            dst     = 16'($urandom);
            mode    = 2'($urandom);
            val     = 8'($urandom);
            done_en = ($urandom_range(0, 5) != 0);
            extra   = int'($urandom_range(0, 2));
            restart = (wc >= 16'd5) && ($urandom_range(0, 1) == 1);
            run_job(wc, mode, val, src, dst, done_en, extra, restart,
                    (wc != 16'd0) && !done_en, 16'(src + wc - 16'd1));
        end

        // Reset in the middle of FEED, after an ignored start while busy.
        tick();
        launch(16'd8, 2'd2, 8'h11, 16'h2000, 16'h3000, 1'b1, 0);
        tick(); tick();
        start = 1'b1;
        word_count = 16'd2;
        tick();
        start = 1'b0;
        check("pre_reset_rd_count", rd_q.size(), 3);
        check("pre_reset_rd_addr", int'(rd_q[rd_q.size()-1]), 16'h2002);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (3) tick();
        p_active = 0;
        clear_mon();
        rst_n = 1'b1;
        repeat (15) tick();
        check("post_reset_rd", rd_q.size(), 0);
        check("post_reset_vld", m_vld_cnt, 0);
        check("post_reset_wr", wa_q.size(), 0);
        check("post_reset_busy", m_busy_cyc, 0);
        check("post_reset_finished", m_fin_cnt, 0);
        $display("job reset-during-feed wc=8 src=0x2000 reads_before_reset=3 writes_after_reset=%0d", wa_q.size());

        run_job(16'd2, 2'd1, 8'h0F, 16'h4000, 16'h5000, 1'b1, 0, 1'b0, 1'b0, 16'h4001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
